// File: rtl/ineq_pkg.sv
// Shared class encodings and FSM states for the inequality window monitor.
package ineq_pkg;
   localparam logic [2:0] CLS_ABOVE  = 3'b100;
   localparam logic [2:0] CLS_INSIDE = 3'b010;
   localparam logic [2:0] CLS_BELOW  = 3'b001;
   localparam logic [2:0] CLS_NONE   = 3'b000;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_TRACK = 1'b1
   } state_e;
endpackage

// File: rtl/ineq_classify.sv
// Combinational 3-way unsigned classifier: one-hot {above, inside, below}.
module ineq_classify
   import ineq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] num,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   output logic [2:0]       raw
);
   always_comb begin
      raw = CLS_INSIDE;
      if (num > hi)      raw = CLS_ABOVE;
      else if (num < lo) raw = CLS_BELOW;
   end
endmodule

// File: rtl/inequality_window_monitor.sv
// Registered window classifier with persistence filtering and programmable thresholds.
module inequality_window_monitor
   import ineq_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int PERSIST = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] num,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] lo_th,
   input  logic [WIDTH-1:0] hi_th,
   input  logic             load,
   output logic [2:0]       out,
   output logic             out_valid,
   output logic             changed,
   output logic             th_error
);
   localparam int SW = $clog2(PERSIST + 1);
   localparam logic [SW-1:0] PMAX = SW'(PERSIST);

   logic [WIDTH-1:0] lo_reg, hi_reg;
   logic [2:0]       cand, cand_n, raw;
   logic [SW-1:0]    streak, streak_n;
   logic             accept, reject, proc, commit;
   state_e           state, state_n;

   ineq_classify #(.WIDTH(WIDTH)) u_cls (
      .num (num),
      .lo  (lo_reg),
      .hi  (hi_reg),
      .raw (raw)
   );

   // An accepted load swallows a coincident sample; a rejected one does not.
   always_comb begin
      accept   = load && (lo_th <= hi_th);
      reject   = load && (lo_th > hi_th);
      proc     = sample_valid && !accept;
      cand_n   = cand;
      streak_n = (streak == PMAX) ? PMAX : streak + SW'(1);
      if (raw != cand) begin
         cand_n   = raw;
         streak_n = SW'(1);
      end
      commit = proc && (streak_n == PMAX) && (cand_n != out);
   end

   always_comb begin
      state_n = state;
      if (state == ST_IDLE && commit) state_n = ST_TRACK;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lo_reg   <= '0;
         hi_reg   <= '1;
         cand     <= CLS_NONE;
         streak   <= '0;
         out      <= CLS_NONE;
         changed  <= 1'b0;
         th_error <= 1'b0;
      end else begin
         th_error <= reject;
         changed  <= commit;
         if (accept) begin
            lo_reg <= lo_th;
            hi_reg <= hi_th;
            streak <= '0;
         end else if (proc) begin
            cand   <= cand_n;
            streak <= streak_n;
         end
         if (commit) out <= cand_n;
      end
   end

   assign out_valid = (state == ST_TRACK);
endmodule
